ram_dump_tx: RTL and testbench

Frame-buffer readback engine: on a start pulse it walks a synchronous 24-bit-wide RAM from address 0 to DEPTH-1, splits each word into three bytes and feeds them one at a time to the UART transmitter through its start/busy handshake. It is the transmit-side counterpart of the serial-to-RAM loader in the VGA serial display path. A host can read back the pixel memory over the same serial link it used to write it, byte order identical to the load order.

---
 rtl/ram_dump_tx.sv | 134 +++++++++++++
 tb/tb_ram_dump_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: frame-buffer readback engine.
// It walks a synchronous 24-bit RAM from address 0 to DEPTH-1. Each word is
// sent to a UART transmitter as three bytes, LSB first, through the
// transmitter's start/busy handshake. The byte order matches the order used
// by the serial-to-RAM loader, so a host can read back exactly what it wrote.
module ram_dump_tx #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] ram_addr,
    input  logic [23:0]   ram_data,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_LATCH,
        S_SEND,
        S_ACK,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    // Compare value that ends a run; the address never has to step past it.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t      state;
    logic [23:0] word;
    logic [1:0]  byte_idx;
    logic [7:0]  cur_byte;

    // Byte lane picked out of the latched word, LSB first.
    always_comb begin
        cur_byte = word[7:0];
        case (byte_idx)
            2'd0:    cur_byte = word[7:0];
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[23:16];
        endcase
    end

    // Control FSM. Every output is registered. tx_start and done are pulses:
    // they default low each cycle and are raised only on the transition
    // that issues them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            ram_addr <= '0;
            tx_data  <= '0;
            word     <= '0;
            byte_idx <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start that arrives while a run is in progress never
                    // reaches this branch, so it is simply dropped.
                    if (start) begin
                        ram_addr <= '0;
                        busy     <= 1'b1;
                        state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // The RAM address is already presented; the read data
                    // appears one cycle later.
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    word     <= ram_data;
                    byte_idx <= 2'd0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= cur_byte;
                        tx_start <= 1'b1;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    // Wait for the transmitter to take the byte. There is
                    // no timeout: a transmitter that never raises busy
                    // stalls the engine here.
                    if (tx_busy) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (byte_idx < 2'd2) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_SEND;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (ram_addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                        state    <= S_RD_WAIT;
                    end
                end
                S_DONE: begin
                    // done is high during this cycle. busy drops one cycle
                    // after done. The address is left at the last word.
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: scoreboard bench for ram_dump_tx.
// A DEPTH=4 instance covers the byte order and the handshake corner cases.
// A DEPTH=1024 instance covers a full-size run.
module tb_ram_dump_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start4, tx_busy4, tx_start4, busy4, done4;
    logic [1:0]  ram_addr4;
    logic [23:0] ram_data4;
    logic [7:0]  tx_data4;

    logic        startb, tx_busyb, tx_startb, busyb, doneb;
    logic [9:0]  ram_addrb;
    logic [23:0] ram_datab;
    logic [7:0]  tx_datab;

    ram_dump_tx #(.DEPTH(4), .AW(2)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .ram_addr(ram_addr4),
        .ram_data(ram_data4), .tx_busy(tx_busy4), .tx_start(tx_start4),
        .tx_data(tx_data4), .busy(busy4), .done(done4)
    );

    ram_dump_tx dutb (
        .clk(clk), .reset(reset), .start(startb), .ram_addr(ram_addrb),
        .ram_data(ram_datab), .tx_busy(tx_busyb), .tx_start(tx_startb),
        .tx_data(tx_datab), .busy(busyb), .done(doneb)
    );

    // Synchronous RAM models with one cycle of read latency.
    logic [23:0] ram4 [4];
    logic [23:0] ramb [1024];
    always @(posedge clk) begin
        ram_data4 <= ram4[ram_addr4];
        ram_datab <= ramb[ram_addrb];
    end

    // Transmitter models. The small one stays busy for 10 cycles after each
    // tx_start. force4 holds it busy, and mute4 makes it ignore tx_start.
    // The big one stays busy for 1 cycle.
    int cnt4 = 0;
    int cntb = 0;
    bit force4 = 1'b0;
    bit mute4 = 1'b0;
    always @(posedge clk) begin
        if (tx_start4 && !mute4) cnt4 <= 10;
        else if (cnt4 != 0)      cnt4 <= cnt4 - 1;
        if (tx_startb)           cntb <= 1;
        else if (cntb != 0)      cntb <= cntb - 1;
    end
    assign tx_busy4 = force4 || (cnt4 != 0);
    assign tx_busyb = (cntb != 0);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [23:0] word;
        logic [7:0]  b0, b1, b2;
    } vec_t;
    vec_t tbl [4];

    logic [7:0] q4 [$];
    logic [7:0] qb [$];

    int nstart4, ndone4, nstartb, ndoneb, wrapb;
    logic prev4 = 1'b0;
    logic prevb = 1'b0;
    logic [9:0] prev_addrb;

    // Monitor: pop the expected byte on every tx_start, and check the
    // handshake rules on the same sample.
    always @(negedge clk) begin
        if (reset) begin
            if (tx_start4) begin
                nstart4++;
                chk("tx_start4_while_busy", 32'(tx_busy4), 0);
                chk("tx_start4_back_to_back", 32'(prev4), 0);
                if (q4.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL byte4_unexpected: got %02h with nothing expected", tx_data4);
                end else begin
                    chk("byte4", 32'(tx_data4), 32'(q4.pop_front()));
                end
            end
            if (done4) ndone4++;
            if (tx_startb) begin
                nstartb++;
                chk("tx_startb_while_busy", 32'(tx_busyb), 0);
                chk("tx_startb_back_to_back", 32'(prevb), 0);
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL byteb_unexpected: got %02h with nothing expected", tx_datab);
                end else begin
                    chk("byteb", 32'(tx_datab), 32'(qb.pop_front()));
                end
            end
            if (doneb) ndoneb++;
            if (busyb) begin
                if (ram_addrb < prev_addrb) wrapb++;
                prev_addrb = ram_addrb;
            end
        end
        prev4 = tx_start4;
        prevb = tx_startb;
    end

    function automatic logic [23:0] gen(input int a);
        logic [9:0] x;
        x = a[9:0];
        return {x[7:0] ^ 8'hA5, 8'(x[9:2] + 8'h3C), 8'(x * 10'd7)};
    endfunction

    task automatic push4();
        for (int i = 0; i < 4; i++) begin
            ram4[i] = tbl[i].word;
            q4.push_back(tbl[i].b0);
            q4.push_back(tbl[i].b1);
            q4.push_back(tbl[i].b2);
        end
    endtask

    task automatic kick4();
        nstart4 = 0;
        ndone4 = 0;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    // Bounded wait for done. busy must still be high on the done cycle and
    // low on the cycle after it.
    task automatic wait_done(input bit big, input int maxc);
        bit seen = 1'b0;
        for (int c = 0; c < maxc && !seen; c++) begin
            @(negedge clk);
            if (big ? doneb : done4) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", maxc);
        end else begin
            chk("busy_on_done", 32'(big ? busyb : busy4), 1);
            @(negedge clk);
            chk("busy_after_done", 32'(big ? busyb : busy4), 0);
            chk("done_single_cycle", 32'(big ? doneb : done4), 0);
        end
    endtask

    task automatic finish4();
        wait_done(1'b0, 3000);
        repeat (3) @(negedge clk);
        chk("tx_start_count", nstart4, 12);
        chk("done_count", ndone4, 1);
        chk("bytes_left", q4.size(), 0);
    endtask

    task automatic wait_nstart4(input int n);
        int c = 0;
        while (nstart4 < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_byte_count", nstart4, n);
    endtask

    initial begin
        tbl[0] = '{24'h112233, 8'h33, 8'h22, 8'h11};
        tbl[1] = '{24'h445566, 8'h66, 8'h55, 8'h44};
        tbl[2] = '{24'h778899, 8'h99, 8'h88, 8'h77};
        tbl[3] = '{24'hAABBCC, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 1024; i++) ramb[i] = gen(i);
        for (int i = 0; i < 4; i++) ram4[i] = tbl[i].word;
        reset = 1'b0;
        start4 = 1'b0;
        startb = 1'b0;
        prev_addrb = '0;

        // Reset values
        #12;
        chk("rst_ram_addr", 32'(ram_addr4), 0);
        chk("rst_tx_start", 32'(tx_start4), 0);
        chk("rst_tx_data", 32'(tx_data4), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_busy_big", 32'(busyb), 0);
        chk("rst_addr_big", 32'(ram_addrb), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic DEPTH=4 run
        push4();
        kick4();
        chk("busy_after_start", 32'(busy4), 1);
        chk("addr_after_start", 32'(ram_addr4), 0);
        finish4();
        chk("addr_held_at_last", 32'(ram_addr4), 3);

        // Transmitter busy before start
        force4 = 1'b1;
        repeat (50) @(negedge clk);
        push4();
        kick4();
        repeat (20) @(negedge clk);
        chk("hold_no_tx_start", nstart4, 0);
        chk("hold_busy", 32'(busy4), 1);
        chk("hold_addr", 32'(ram_addr4), 0);
        force4 = 1'b0;
        finish4();

        // start pulsed again mid-run is ignored
        push4();
        kick4();
        wait_nstart4(5);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        finish4();

        // Async reset mid byte 7, then a full rerun
        push4();
        kick4();
        wait_nstart4(7);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ram_addr", 32'(ram_addr4), 0);
        chk("mid_rst_tx_start", 32'(tx_start4), 0);
        chk("mid_rst_tx_data", 32'(tx_data4), 0);
        chk("mid_rst_busy", 32'(busy4), 0);
        chk("mid_rst_done", 32'(done4), 0);
        q4.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        push4();
        kick4();
        finish4();

        // Transmitter never acknowledges
        mute4 = 1'b1;
        push4();
        kick4();
        repeat (100) @(negedge clk);
        chk("mute_tx_start_count", nstart4, 1);
        chk("mute_busy", 32'(busy4), 1);
        chk("mute_done_count", ndone4, 0);
        q4.delete();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mute4 = 1'b0;
        repeat (2) @(negedge clk);

        // Full-size DEPTH=1024 run
        for (int i = 0; i < 1024; i++) begin
            logic [23:0] w;
            w = ramb[i];
            qb.push_back(w[7:0]);
            qb.push_back(w[15:8]);
            qb.push_back(w[23:16]);
        end
        nstartb = 0;
        ndoneb = 0;
        wrapb = 0;
        prev_addrb = '0;
        startb = 1'b1;
        @(negedge clk);
        startb = 1'b0;
        wait_done(1'b1, 40000);
        repeat (2) @(negedge clk);
        chk("big_tx_start_count", nstartb, 3072);
        chk("big_done_count", ndoneb, 1);
        chk("big_addr_no_wrap", wrapb, 0);
        chk("big_addr_final", 32'(ram_addrb), 1023);
        chk("big_bytes_left", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
